// File: rtl/ca_row_renderer_if.sv
// ca_row_renderer_if
// Bundles the sync-generator timing inputs, the rule number and the
// registered VGA outputs of the cellular-automaton row renderer.
// master: sync generator / pixel source side; slave: the renderer.
interface ca_row_renderer_if;
    logic [9:0] CounterX;
    logic [9:0] CounterY;
    logic       inDisplayArea;
    logic       vga_h_sync_in;
    logic       vga_v_sync_in;
    logic [7:0] rule;
    logic       vga_r;
    logic       vga_g;
    logic       vga_b;
    logic       vga_h_sync;
    logic       vga_v_sync;

    modport master (
        output CounterX, CounterY, inDisplayArea, vga_h_sync_in, vga_v_sync_in, rule,
        input  vga_r, vga_g, vga_b, vga_h_sync, vga_v_sync
    );

    modport slave (
        input  CounterX, CounterY, inDisplayArea, vga_h_sync_in, vga_v_sync_in, rule,
        output vga_r, vga_g, vga_b, vga_h_sync, vga_v_sync
    );
endinterface

// File: rtl/ca_row_renderer.sv
// ca_row_renderer
// Renders a one-dimensional elementary cellular automaton on a VGA raster:
// display row y shows generation y, starting from a single live cell.
// While a line is scanned, the next generation is built one cell per clock
// alongside the pixel being shown; it replaces the current row at the end
// of the line.
// Optional feature: define CA_RULE_CYCLE_EN to step the rule number by one
// at every frame start (the rule port is then sampled only at reset).
module ca_row_renderer #(
    parameter logic [9:0] SEED_X = 10'd320,
    parameter int         ROW_W  = 640
) (
    input  logic              clk,
    input  logic              rst,
    ca_row_renderer_if.slave  bus
);

    localparam int                 IDX_W    = $clog2(ROW_W);
    localparam logic [9:0]         ROW_W_C  = 10'(ROW_W);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(ROW_W - 1);
    localparam logic [IDX_W-1:0]   ONE_IDX  = IDX_W'(1);
    localparam logic [ROW_W-1:0]   SEED_ROW = {{(ROW_W-1){1'b0}}, 1'b1} << SEED_X;

    // HOLD: after reset, keep showing the seed row and suppress row updates
    // until the first frame start. RUN: normal generation stepping.
    typedef enum logic {ST_HOLD, ST_RUN} state_t;

    state_t            state;
    state_t            state_next;
    logic              row_upd_en;

    logic [ROW_W-1:0]  cur;
    logic [ROW_W-1:0]  nxt;
    logic [7:0]        rule_q;

    logic              frame_start;
    logic              row_end;
    logic              col_valid;
    logic [9:0]        col;
    logic [IDX_W-1:0]  col_i;
    logic [IDX_W-1:0]  left_i;
    logic [IDX_W-1:0]  right_i;
    logic [2:0]        nbhd;
    logic              pix_p0;

    // The column under the beam lags CounterX by one (inDisplayArea is
    // registered upstream), so both the pixel and the next-generation cell
    // use x = CounterX-1. This also keeps the frame-start clock (CounterX==0)
    // free of any nxt write, so generation 1 is built from the fresh seed.
    assign frame_start = (bus.CounterX == 10'd0) && (bus.CounterY == 10'd0);
    assign row_end     = (bus.CounterX == 10'd799) && (bus.CounterY < 10'd479);
    assign col_valid   = (bus.CounterX != 10'd0) && (bus.CounterX <= ROW_W_C);
    assign col         = bus.CounterX - 10'd1;
    assign col_i       = col[IDX_W-1:0];
    assign left_i      = (col_i == '0) ? LAST_IDX : col_i - ONE_IDX;
    assign right_i     = (col_i == LAST_IDX) ? '0 : col_i + ONE_IDX;
    assign nbhd        = {cur[left_i], cur[col_i], cur[right_i]};
    assign pix_p0      = bus.inDisplayArea && col_valid && cur[col_i];

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_HOLD;
        end else begin
            state <= state_next;
        end
    end

    // Next state and row-update permission.
    always_comb begin
        state_next = state;
        row_upd_en = 1'b0;
        case (state)
            ST_HOLD: begin
                if (frame_start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                row_upd_en = 1'b1;
            end
            default: begin
                state_next = ST_HOLD;
            end
        endcase
    end

    // Generation storage: build nxt during the line, swap at line end;
    // a frame start reloads the seed and wins over any row update.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur    <= SEED_ROW;
            nxt    <= '0;
            rule_q <= bus.rule;
        end else begin
            if (col_valid) begin
                nxt[col_i] <= rule_q[nbhd];
            end
            if (frame_start) begin
                cur <= SEED_ROW;
`ifdef CA_RULE_CYCLE_EN
                rule_q <= rule_q + 8'd1;
`else
                rule_q <= bus.rule;
`endif
            end else if (row_end && row_upd_en) begin
                cur <= nxt;
            end
        end
    end

    // Output stage: colour and syncs registered together so they stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.vga_r      <= 1'b0;
            bus.vga_g      <= 1'b0;
            bus.vga_b      <= 1'b0;
            bus.vga_h_sync <= 1'b1;
            bus.vga_v_sync <= 1'b1;
        end else begin
            bus.vga_r      <= pix_p0;
            bus.vga_g      <= pix_p0;
            bus.vga_b      <= pix_p0;
            bus.vga_h_sync <= bus.vga_h_sync_in;
            bus.vga_v_sync <= bus.vga_v_sync_in;
        end
    end

endmodule

// File: tb/tb_ca_row_renderer.sv
// tb_ca_row_renderer
// Scoreboard bench for ca_row_renderer: two instances (seed at 320 and at 0)
// are driven with the same compressed raster; expected outputs are pushed
// when inputs are applied and compared one clock later.
module tb_ca_row_renderer;

    logic clk;
    logic rst;
    logic [7:0] rule_v;

    ca_row_renderer_if bus0 ();
    ca_row_renderer_if bus1 ();

    ca_row_renderer #(.SEED_X(10'd320), .ROW_W(640)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    ca_row_renderer #(.SEED_X(10'd0), .ROW_W(640)) u_dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         x;
        int         y;
        logic       rst;
        logic [4:0] e0;
        logic [4:0] e1;
    } ent_t;

    ent_t sb[$];

    int n_vec;
    int n_bad;

    logic [639:0] mcur [2];
    logic [7:0]   mrule [2];
    logic         mrun [2];
    logic [639:0] acc [2];
    logic [639:0] line [2];

    task automatic check_eq(input string tag, input logic [639:0] got, input logic [639:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [639:0] seed_of(input int i);
        logic [639:0] v;
        v = '0;
        if (i == 0) v[320] = 1'b1;
        else        v[0]   = 1'b1;
        return v;
    endfunction

    function automatic logic [639:0] pat(input int a, input int b = -1, input int c = -1, input int d = -1);
        logic [639:0] v;
        v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        if (c >= 0) v[c] = 1'b1;
        if (d >= 0) v[d] = 1'b1;
        return v;
    endfunction

    function automatic logic [639:0] ca_step(input logic [639:0] c, input logic [7:0] r);
        logic [639:0] n;
        logic [2:0]   k;
        for (int x = 0; x < 640; x++) begin
            k    = {c[(x + 639) % 640], c[x], c[(x + 1) % 640]};
            n[x] = r[k];
        end
        return n;
    endfunction

    function automatic logic [4:0] outs(input int i);
        if (i == 0) return {bus0.vga_r, bus0.vga_g, bus0.vga_b, bus0.vga_h_sync, bus0.vga_v_sync};
        else        return {bus1.vga_r, bus1.vga_g, bus1.vga_b, bus1.vga_h_sync, bus1.vga_v_sync};
    endfunction

    // One clock: compare what the last edge produced, then apply new inputs.
    task automatic step(input int x, input int y, input logic r);
        ent_t       e;
        logic [4:0] got;
        logic       disp;
        logic       hs;
        logic       vs;
        logic       pix;
        logic [4:0] ex [2];
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int i = 0; i < 2; i++) begin
                got = outs(i);
                check_eq((i == 0) ? "pix_seed320" : "pix_seed0", got, (i == 0) ? e.e0 : e.e1);
                if (e.x >= 1 && e.x <= 640) acc[i][e.x - 1] = got[4];
                if (e.x == 640) line[i] = acc[i];
            end
            if (e.rst) check_eq("rst_out", outs(0), 5'b00011);
            if (e.x == 655 && !e.rst) check_eq("hs_before_656", outs(0), {outs(0)[4:2], 1'b1, outs(0)[0]});
            if (e.x == 656 && !e.rst) check_eq("hs_fall_657", {4'b0, outs(0)[1]}, 5'b0);
        end
        disp = (x >= 1) && (x <= 640) && (y < 480);
        hs   = !((x >= 656) && (x < 752));
        vs   = !((y == 490) || (y == 491));
        rst  = r;
        bus0.CounterX = 10'(x);  bus1.CounterX = 10'(x);
        bus0.CounterY = 10'(y);  bus1.CounterY = 10'(y);
        bus0.inDisplayArea = disp; bus1.inDisplayArea = disp;
        bus0.vga_h_sync_in = hs;   bus1.vga_h_sync_in = hs;
        bus0.vga_v_sync_in = vs;   bus1.vga_v_sync_in = vs;
        bus0.rule = rule_v;        bus1.rule = rule_v;
        for (int i = 0; i < 2; i++) begin
            pix   = disp && mcur[i][x - 1];
            ex[i] = r ? 5'b00011 : {pix, pix, pix, hs, vs};
            if (r) begin
                mcur[i]  = seed_of(i);
                mrule[i] = rule_v;
                mrun[i]  = 1'b0;
            end else if (x == 0 && y == 0) begin
                mcur[i]  = seed_of(i);
                mrule[i] = rule_v;
                mrun[i]  = 1'b1;
            end else if (x == 799 && y < 479 && mrun[i]) begin
                mcur[i] = ca_step(mcur[i], mrule[i]);
            end
        end
        e.x = x; e.y = y; e.rst = r; e.e0 = ex[0]; e.e1 = ex[1];
        sb.push_back(e);
    endtask

    task automatic run_row(input int y);
        for (int x = 0; x < 800; x++) step(x, y, 1'b0);
    endtask

    initial begin
        n_vec  = 0;
        n_bad  = 0;
        rst    = 1'b1;
        rule_v = 8'd90;
        bus0.CounterX = 10'd700; bus1.CounterX = 10'd700;
        bus0.CounterY = 10'd520; bus1.CounterY = 10'd520;
        bus0.inDisplayArea = 1'b0; bus1.inDisplayArea = 1'b0;
        bus0.vga_h_sync_in = 1'b1; bus1.vga_h_sync_in = 1'b1;
        bus0.vga_v_sync_in = 1'b1; bus1.vga_v_sync_in = 1'b1;
        bus0.rule = 8'd90;         bus1.rule = 8'd90;
        for (int i = 0; i < 2; i++) begin
            mcur[i] = seed_of(i); mrule[i] = 8'd90; mrun[i] = 1'b0;
            acc[i] = '0; line[i] = '0;
        end

        // Reset, then a rule-90 frame.
        for (int k = 0; k < 3; k++) step(700 + k, 520, 1'b1);
        step(703, 520, 1'b0);
        run_row(0);
        check_eq("r90_gen0", line[0], pat(320));
        run_row(1);
        check_eq("r90_gen1", line[0], pat(319, 321));
        check_eq("wrap_gen1", line[1], pat(639, 1));
        run_row(2);
        check_eq("r90_gen2", line[0], pat(318, 322));

        // Rule port changes mid-frame; this frame must stay rule 90.
        rule_v = 8'd30;
        run_row(100);
        check_eq("r90_gen3", line[0], pat(317, 319, 321, 323));
        run_row(101);
        check_eq("rule_hold_gen4", line[0], pat(316, 324));
        run_row(490);
        run_row(524);

        // Next frame renders rule 30.
        run_row(0);
        run_row(1);
        check_eq("r30_gen1", line[0], pat(319, 320, 321));

        // Reset pulse in the middle of a visible line.
        rule_v = 8'd90;
        run_row(0);
        for (int x = 0; x < 800; x++) step(x, 50, x == 300);
        run_row(51);
        check_eq("seed_hold", line[0], pat(320));
        run_row(0);
        run_row(1);
        check_eq("post_rst_gen1", line[0], pat(319, 321));

        // Rule 0: only the seed pixel on row 0.
        rule_v = 8'd0;
        run_row(0);
        check_eq("r0_row0", line[0], pat(320));
        run_row(1);
        check_eq("r0_row1", line[0], '0);
        run_row(479);
        check_eq("r0_row479", line[0], '0);

        step(0, 520, 1'b0);
        step(1, 520, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
